// File: rtl/dii_pkg.sv
// dii_pkg: shared DII flit constants, header layout and packetizer state encoding.
package dii_pkg;
  localparam int DII_FLIT_W = 16;
  localparam logic [1:0] TYPE_REG = 2'd0;
  localparam logic [1:0] TYPE_PLAIN = 2'd1;
  localparam logic [1:0] TYPE_EVENT = 2'd2;
  localparam int HDR_TYPE_LSB = 14;
  localparam int HDR_TYPE_W = 2;
  localparam int HDR_SUB_LSB = 10;
  localparam int HDR_SUB_W = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_SRC, ST_HDR, ST_PAYLOAD} state_t;
  function automatic logic [DII_FLIT_W-1:0] hdr_flit(input logic [HDR_TYPE_W-1:0] t, input logic [HDR_SUB_W-1:0] s);
    logic [DII_FLIT_W-1:0] f;
    f = '0;
    f[HDR_TYPE_LSB +: HDR_TYPE_W] = t;
    f[HDR_SUB_LSB +: HDR_SUB_W] = s;
    return f;
  endfunction
endpackage

// File: rtl/dii_flit_reg.sv
// dii_flit_reg: single-entry valid/ready output register holding one flit and its last flag.
module dii_flit_reg
  import dii_pkg::*;
#(
  parameter int W = DII_FLIT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_last,
  input  logic         i_ready,
  output logic         o_load_en,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_last
);
  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_last;
  assign o_load_en = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data = r_data;
  assign o_last = r_last;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (o_load_en) begin
      r_valid <= i_load;
      if (i_load) begin
        r_data <= i_data;
        r_last <= i_last;
      end
    end
  end
endmodule

// File: rtl/dii_packetizer.sv
// dii_packetizer: builds one DII packet (DEST, SRC, HDR, payload) per request
// and streams it through a registered valid/ready output stage.
module dii_packetizer
  import dii_pkg::*;
#(
  parameter int MAX_PAYLOAD = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      id,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_dest,
  input  logic [1:0]       req_type,
  input  logic [3:0]       req_subtype,
  input  logic [LEN_W-1:0] req_len,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic [15:0]      pl_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic             len_err
);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_PAYLOAD);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
  state_t           r_state;
  logic [15:0]      r_id;
  logic [1:0]       r_type;
  logic [3:0]       r_sub;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_len_err;
  logic             w_load_en;
  logic             w_req_fire;
  logic             w_pl_fire;
  logic             w_over;
  logic [LEN_W-1:0] w_len_eff;
  logic             w_load;
  logic [15:0]      w_data;
  logic             w_last;
  assign w_over = req_len > MAX_L;
  assign w_len_eff = w_over ? MAX_L : req_len;
  assign req_ready = !rst && r_state == ST_IDLE && w_load_en;
  assign pl_ready = !rst && r_state == ST_PAYLOAD && w_load_en;
  assign w_req_fire = req_valid && req_ready;
  assign w_pl_fire = pl_valid && pl_ready;
  assign len_err = r_len_err;
  // Next flit is chosen by the state that is about to be left, so each state emits its own flit.
  always_comb begin
    w_load = w_req_fire || w_pl_fire || (w_load_en && (r_state == ST_SRC || r_state == ST_HDR));
    w_data = r_state == ST_IDLE ? req_dest :
             r_state == ST_SRC  ? r_id :
             r_state == ST_HDR  ? hdr_flit(r_type, r_sub) : pl_data;
    w_last = (r_state == ST_HDR && r_len == '0) || (r_state == ST_PAYLOAD && r_cnt == ONE_L);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_id <= '0;
      r_type <= '0;
      r_sub <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_req_fire && w_over;
      case (r_state)
        ST_IDLE: if (w_req_fire) begin
          r_id <= id;
          r_type <= req_type;
          r_sub <= req_subtype;
          r_len <= w_len_eff;
          r_state <= ST_SRC;
        end
        ST_SRC: if (w_load_en) r_state <= ST_HDR;
        ST_HDR: if (w_load_en) begin
          r_cnt <= r_len;
          r_state <= r_len == '0 ? ST_IDLE : ST_PAYLOAD;
        end
        ST_PAYLOAD: if (w_pl_fire) begin
          r_cnt <= r_cnt - ONE_L;
          if (r_cnt == ONE_L) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  dii_flit_reg #(.W(DII_FLIT_W)) u_out (
    .clk(clk),
    .rst(rst),
    .i_load(w_load),
    .i_data(w_data),
    .i_last(w_last),
    .i_ready(out_ready),
    .o_load_en(w_load_en),
    .o_valid(out_valid),
    .o_data(out_data),
    .o_last(out_last)
  );
endmodule
